// File: rtl/iir_pkg.sv
// Shared types and default widths for the IIR second-order-section datapath.
package iir_pkg;

    localparam int unsigned DEF_WA        = 18;
    localparam int unsigned DEF_WB        = 25;
    localparam int unsigned DEF_COEF_FRAC = 16;
    localparam int unsigned ACC_W         = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } sos_state_t;

    typedef struct packed {
        logic signed [DEF_WA-1:0] b0;
        logic signed [DEF_WA-1:0] b1;
        logic signed [DEF_WA-1:0] b2;
        logic signed [DEF_WA-1:0] na1;
        logic signed [DEF_WA-1:0] na2;
    } sos_coef_t;

endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-up and saturate from a wide accumulator to the sample width.
module iir_round_sat #(
    parameter int unsigned WC   = 48,
    parameter int unsigned WO   = 25,
    parameter int unsigned FRAC = 16
) (
    input  logic signed [WC-1:0] acc,
    output logic signed [WO-1:0] y
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam int unsigned WS = WC + 1;
    localparam logic signed [WS-1:0] HALF = {{(WS-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [WS-1:0] MAXV = {{(WS-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WS-1:0] MINV = {{(WS-WO+1){1'b1}}, {(WO-1){1'b0}}};

    logic signed [WS-1:0] biased;
    logic signed [WS-1:0] shifted;

    always_comb begin
        biased  = WS'(acc) + HALF;
        shifted = biased >>> FRAC;
        if (shifted > MAXV) begin
            y = MAXV[WO-1:0];
        end else if (shifted < MINV) begin
            y = MINV[WO-1:0];
        end else begin
            y = shifted[WO-1:0];
        end
    end

endmodule

// File: rtl/iir_sos_sequencer.sv
// Direct Form I biquad sequencer: drives a shared MAC through five products per sample,
// then rounds/saturates the sum, updates history and hands y downstream.
module iir_sos_sequencer
    import iir_pkg::*;
#(
    parameter int unsigned Wa        = DEF_WA,
    parameter int unsigned Wb        = DEF_WB,
    parameter int unsigned COEF_FRAC = DEF_COEF_FRAC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic signed [Wa-1:0]  coef_b0,
    input  logic signed [Wa-1:0]  coef_b1,
    input  logic signed [Wa-1:0]  coef_b2,
    input  logic signed [Wa-1:0]  coef_na1,
    input  logic signed [Wa-1:0]  coef_na2,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [Wb-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [Wb-1:0]  out_data,
    output logic                  mac_en,
    output logic                  mac_ld,
    output logic signed [Wa-1:0]  mac_a,
    output logic signed [Wb-1:0]  mac_b,
    input  logic signed [ACC_W-1:0] mac_c
);

    sos_state_t state, state_nx;
    logic [2:0] step, step_nx;
    sos_coef_t  coef;
    logic signed [Wb-1:0] x0, x1, x2, y1, y2;
    logic signed [Wb-1:0] sat;
    logic accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    iir_round_sat #(
        .WC   (ACC_W),
        .WO   (Wb),
        .FRAC (COEF_FRAC)
    ) u_round_sat (
        .acc (mac_c),
        .y   (sat)
    );

    // State and MAC step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 3'd0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
        end
    end

    // Next state and MAC operand selection; step 0 restarts the accumulator.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        mac_en   = 1'b0;
        mac_ld   = 1'b0;
        mac_a    = '0;
        mac_b    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = MAC;
                    step_nx  = 3'd0;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                mac_ld = (step == 3'd0);
                case (step)
                    3'd0:    begin mac_a = Wa'(coef.b0);  mac_b = x0; end
                    3'd1:    begin mac_a = Wa'(coef.b1);  mac_b = x1; end
                    3'd2:    begin mac_a = Wa'(coef.b2);  mac_b = x2; end
                    3'd3:    begin mac_a = Wa'(coef.na1); mac_b = y1; end
                    default: begin mac_a = Wa'(coef.na2); mac_b = y2; end
                endcase
                if (step == 3'd4) begin
                    state_nx = ROUND;
                end else begin
                    step_nx = step + 3'd1;
                end
            end
            ROUND: state_nx = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sample/coefficient capture, history shift and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef      <= '0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (clear) begin
                    x1 <= '0;
                    x2 <= '0;
                    y1 <= '0;
                    y2 <= '0;
                end
                if (accept) begin
                    x0   <= in_data;
                    coef <= '{b0:  DEF_WA'(coef_b0),
                              b1:  DEF_WA'(coef_b1),
                              b2:  DEF_WA'(coef_b2),
                              na1: DEF_WA'(coef_na1),
                              na2: DEF_WA'(coef_na2)};
                end
            end
            if (state == ROUND) begin
                out_data  <= sat;
                out_valid <= 1'b1;
                x2        <= x1;
                x1        <= x0;
                y2        <= y1;
                y1        <= sat;
            end
            if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iir_sos_sequencer.sv
// Directed bench for iir_sos_sequencer with a behavioural MAC and an expected-output queue.
module tb_iir_sos_sequencer;

    localparam int unsigned WA = 18;
    localparam int unsigned WB = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic signed [WA-1:0] coef_b0 = '0, coef_b1 = '0, coef_b2 = '0, coef_na1 = '0, coef_na2 = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [WB-1:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [WB-1:0] out_data;
    logic mac_en, mac_ld;
    logic signed [WA-1:0] mac_a;
    logic signed [WB-1:0] mac_b;
    logic signed [47:0] mac_c;

    int total = 0;
    int bad = 0;
    logic signed [WB-1:0] sb[$];
    logic signed [WA-1:0] cap_a[5];
    logic signed [WB-1:0] cap_b[5];

    always #5 clk = ~clk;

    iir_sos_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
        .coef_na1(coef_na1), .coef_na2(coef_na2),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mac_en(mac_en), .mac_ld(mac_ld), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c)
    );

    // Behavioural single-DSP multiply-accumulate with registered result.
    logic signed [47:0] prod;
    assign prod = 48'(longint'(mac_a) * longint'(mac_b));
    always @(posedge clk) begin
        if (mac_en) mac_c <= mac_ld ? prod : mac_c + prod;
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_coefs(input int b0, input int b1, input int b2, input int na1, input int na2);
        coef_b0 = WA'(b0); coef_b1 = WA'(b1); coef_b2 = WA'(b2);
        coef_na1 = WA'(na1); coef_na2 = WA'(na2);
    endtask

    // One sample through the full handshake; coefficients are scrambled while in flight.
    task automatic send(input logic signed [WB-1:0] x, input logic signed [WB-1:0] y_exp,
                        input int stall, input bit hold, input bit clr);
        logic signed [WA-1:0] s0, s1, s2, s3, s4;
        logic signed [WB-1:0] held, y_e;
        int n;
        sb.push_back(y_exp);
        @(negedge clk);
        in_data = x; in_valid = 1'b1; clear = clr; out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 40), 1);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        clear = 1'b0;
        s0 = coef_b0; s1 = coef_b1; s2 = coef_b2; s3 = coef_na1; s4 = coef_na2;
        coef_b0 = WA'($urandom); coef_b1 = WA'($urandom); coef_b2 = WA'($urandom);
        coef_na1 = WA'($urandom); coef_na2 = WA'($urandom);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mac_en", 64'(mac_en), 1);
            chk("mac_ld", 64'(mac_ld), 64'(k == 0));
            cap_a[k] = mac_a;
            cap_b[k] = mac_b;
        end
        @(negedge clk);
        chk("round_mac_en", 64'(mac_en), 0);
        chk("round_out_valid", 64'(out_valid), 0);
        chk("round_in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        chk("latency6", 64'(out_valid), 1);
        coef_b0 = s0; coef_b1 = s1; coef_b2 = s2; coef_na1 = s3; coef_na2 = s4;
        chk("sb_depth", 64'(sb.size()), 1);
        if (sb.size() > 0) begin
            y_e = sb.pop_front();
            chk("out_data", out_data, y_e);
        end
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 1);
            chk("stall_data", out_data, held);
            chk("stall_in_ready", 64'(in_ready), 0);
        end
        if (stall > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("out_drop", 64'(out_valid), 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        logic signed [WA-1:0] ea[5];
        logic signed [WB-1:0] eb[5];
        int n;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mac_en", 64'(mac_en), 0);
        chk("rst_mac_ld", 64'(mac_ld), 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Passthrough
        set_coefs(65536, 0, 0, 0, 0);
        send(25'sd1000, 25'sd1000, 0, 1'b0, 1'b1);
        send(-25'sd7, -25'sd7, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd0, 0, 1'b0, 1'b0);

        // Recursion with round-half-up
        set_coefs(65536, 0, 0, 32768, 0);
        send(25'sd1000, 25'sd1000, 0, 1'b0, 1'b1);
        send(25'sd0, 25'sd500, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd250, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd125, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd63, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd32, 0, 1'b0, 1'b0);

        // Clear alone in IDLE restarts the impulse response
        do_clear();
        send(25'sd1000, 25'sd1000, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd500, 0, 1'b0, 1'b0);

        // MAC operand order
        set_coefs(65536, 32768, 16384, -32768, 8192);
        send(25'sd4096, 25'sd4096, 0, 1'b0, 1'b1);
        send(25'sd0, 25'sd0, 0, 1'b0, 1'b0);
        ea = '{18'sd65536, 18'sd32768, 18'sd16384, -18'sd32768, 18'sd8192};
        eb = '{25'sd0, 25'sd4096, 25'sd0, 25'sd4096, 25'sd0};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("s1_mac_a%0d", k), cap_a[k], ea[k]);
            chk($sformatf("s1_mac_b%0d", k), cap_b[k], eb[k]);
        end
        send(25'sd0, 25'sd1536, 0, 1'b0, 1'b0);
        eb = '{25'sd0, 25'sd0, 25'sd4096, 25'sd0, 25'sd4096};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("s2_mac_a%0d", k), cap_a[k], ea[k]);
            chk($sformatf("s2_mac_b%0d", k), cap_b[k], eb[k]);
        end

        // Saturation both directions
        set_coefs(65536, 65536, 0, 0, 0);
        send(25'sd16777215, 25'sd16777215, 0, 1'b0, 1'b1);
        send(25'sd16777215, 25'sd16777215, 0, 1'b0, 1'b0);
        send(-25'sd16777216, -25'sd16777216, 0, 1'b0, 1'b1);
        send(-25'sd16777216, -25'sd16777216, 0, 1'b0, 1'b0);

        // Backpressure with in_valid held high
        set_coefs(65536, 0, 0, 0, 0);
        send(25'sd12345, 25'sd12345, 10, 1'b1, 1'b1);
        send(-25'sd222, -25'sd222, 0, 1'b0, 1'b0);

        // Reset during MAC step 2 aborts and clears history
        set_coefs(65536, 0, 0, 32768, 0);
        @(negedge clk);
        chk("pre_rst_in_ready", 64'(in_ready), 1);
        in_data = 25'sd777; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("step2_mac_en", 64'(mac_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 0);
        chk("abort_mac_en", 64'(mac_en), 0);
        chk("abort_in_ready", 64'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        send(25'sd1000, 25'sd1000, 0, 1'b0, 1'b0);
        send(25'sd0, 25'sd500, 0, 1'b0, 1'b0);

        // Reset while holding a result drops out_valid at once
        @(negedge clk);
        in_data = 25'sd4321; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_hold_out_valid", 64'(out_valid), 0);
        chk("rst_hold_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
